// File: rtl/render_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : render_ctrl_pkg
//  Description : Shared types and constants for the per-frame render
//                sequencer (frame_render_ctrl).
//                  state_t            - sequencer state encoding
//                  CLEAR_GUARD_CYCLES - cycles after the clear request during
//                                       which i_fb_ready is not trusted
//  Revision    : 1.0 - initial release
// ============================================================================
package render_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CLEAR      = 3'd1,
        CLEAR_WAIT = 3'd2,
        START      = 3'd3,
        RENDER     = 3'd4,
        DONE       = 3'd5
    } state_t;

    // The display may still report the previous "ready" for a couple of
    // cycles after it receives a clear request, so it is ignored meanwhile.
    localparam int CLEAR_GUARD_CYCLES = 2;

endpackage
`default_nettype wire

// File: rtl/frame_render_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : frame_render_ctrl
//  Description : Per-frame sequencer between the MCU link and the
//                render_pipeline / display. Accepts a frame descriptor,
//                requests a framebuffer clear, waits for it, then launches
//                the render pipeline once per object, drives the object index
//                and reports frame completion. A per-object watchdog aborts a
//                frame whose pipeline never finishes.
//
//  Ports
//    clk                in   system clock
//    rstn               in   asynchronous active-low reset
//    i_frame_dv         in   frame descriptor valid (held until accepted)
//    i_num_objects      in   objects in the frame (sampled on accept)
//    o_frame_ready      out  idle, descriptor can be accepted
//    o_fb_clear         out  1-cycle framebuffer clear request
//    i_fb_ready         in   display idle / clear complete
//    o_render_start     out  1-cycle start pulse to render_pipeline
//    i_render_ready     in   render_pipeline idle
//    i_render_finished  in   1-cycle object-done pulse
//    o_object_index     out  object currently being rendered
//    o_frame_done       out  1-cycle end-of-frame pulse
//    o_timeout_err      out  sticky watchdog flag, cleared on next accept
//
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_render_ctrl
    import render_ctrl_pkg::*;
#(
    parameter int MAX_NUM_OBJECTS_PER_FRAME = 1024,
    parameter int OBJ_CNT_WIDTH             = $clog2(MAX_NUM_OBJECTS_PER_FRAME + 1),
    parameter int TIMEOUT_CYCLES            = 2**24,
    parameter int TIMEOUT_WIDTH             = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_frame_dv,
    input  logic [OBJ_CNT_WIDTH-1:0] i_num_objects,
    output logic                     o_frame_ready,
    output logic                     o_fb_clear,
    input  logic                     i_fb_ready,
    output logic                     o_render_start,
    input  logic                     i_render_ready,
    input  logic                     i_render_finished,
    output logic [OBJ_CNT_WIDTH-1:0] o_object_index,
    output logic                     o_frame_done,
    output logic                     o_timeout_err
);

    // A disabled watchdog (TIMEOUT_CYCLES = 0) would give a zero-width
    // counter; keep at least one bit so the logic stays legal.
    localparam int c_wd_width    = (TIMEOUT_WIDTH < 1) ? 1 : TIMEOUT_WIDTH;
    localparam bit c_wd_enable   = (TIMEOUT_CYCLES != 0);
    localparam int c_guard_width = ($clog2(CLEAR_GUARD_CYCLES) < 1) ? 1 : $clog2(CLEAR_GUARD_CYCLES);

    localparam logic [OBJ_CNT_WIDTH-1:0] c_obj_max = OBJ_CNT_WIDTH'(MAX_NUM_OBJECTS_PER_FRAME);
    localparam logic [OBJ_CNT_WIDTH-1:0] c_obj_one = OBJ_CNT_WIDTH'(1);
    // Watchdog value seen during the last RENDER cycle before expiry.
    localparam logic [c_wd_width-1:0]    c_wd_last = c_wd_enable ? c_wd_width'(TIMEOUT_CYCLES - 1)
                                                                 : '0;
    localparam logic [c_wd_width-1:0]    c_wd_sat  = {c_wd_width{1'b1}};
    localparam logic [c_wd_width-1:0]    c_wd_one  = c_wd_width'(1);
    // The CLEAR cycle itself is the first guard cycle, so CLEAR_WAIT only
    // needs to hold off for the remainder.
    localparam logic [c_guard_width-1:0] c_guard_load = c_guard_width'(CLEAR_GUARD_CYCLES - 1);
    localparam logic [c_guard_width-1:0] c_guard_one  = c_guard_width'(1);

    state_t                     r_state;
    state_t                     w_next_state;
    logic [OBJ_CNT_WIDTH-1:0]   r_num_obj;
    logic [c_guard_width-1:0]   r_guard;
    logic [c_wd_width-1:0]      r_wd;

    logic                       w_accept;
    logic                       w_last_obj;
    logic                       w_wd_expired;
    logic [OBJ_CNT_WIDTH-1:0]   w_num_sat;

    // o_frame_ready is part of the accept term so that no descriptor is
    // taken in the cycle right after reset release.
    assign w_accept     = (r_state == IDLE) && i_frame_dv && o_frame_ready;
    assign w_num_sat    = (i_num_objects > c_obj_max) ? c_obj_max : i_num_objects;
    // Only evaluated in RENDER, where r_num_obj is known to be non-zero.
    assign w_last_obj   = (o_object_index == (r_num_obj - c_obj_one));
    assign w_wd_expired = c_wd_enable && (r_wd == c_wd_last);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = CLEAR;
                end
            end
            CLEAR: begin
                w_next_state = CLEAR_WAIT;
            end
            CLEAR_WAIT: begin
                if ((r_guard == '0) && i_fb_ready) begin
                    w_next_state = (r_num_obj != '0) ? START : DONE;
                end
            end
            START: begin
                if (i_render_ready) begin
                    w_next_state = RENDER;
                end
            end
            RENDER: begin
                // A finish in the same cycle as expiry still counts.
                if (i_render_finished) begin
                    w_next_state = w_last_obj ? DONE : START;
                end else if (w_wd_expired) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs and counters. Pulse outputs are decoded from the
    // next state so they line up with the state they belong to.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_frame_ready  <= 1'b0;
            o_fb_clear     <= 1'b0;
            o_render_start <= 1'b0;
            o_frame_done   <= 1'b0;
            o_timeout_err  <= 1'b0;
            o_object_index <= '0;
            r_num_obj      <= '0;
            r_guard        <= '0;
            r_wd           <= '0;
        end else begin
            o_frame_ready  <= (w_next_state == IDLE);
            o_fb_clear     <= (w_next_state == CLEAR);
            o_render_start <= (r_state == START) && (w_next_state == RENDER);
            o_frame_done   <= (w_next_state == DONE);

            if (w_accept) begin
                r_num_obj      <= w_num_sat;
                o_object_index <= '0;
                o_timeout_err  <= 1'b0;
            end

            if (r_state == CLEAR) begin
                r_guard <= c_guard_load;
            end else if ((r_state == CLEAR_WAIT) && (r_guard != '0)) begin
                r_guard <= r_guard - c_guard_one;
            end

            if (r_state == START) begin
                r_wd <= '0;
            end else if ((r_state == RENDER) && (r_wd != c_wd_sat)) begin
                r_wd <= r_wd + c_wd_one;
            end

            if (r_state == RENDER) begin
                if (i_render_finished) begin
                    if (!w_last_obj) begin
                        o_object_index <= o_object_index + c_obj_one;
                    end
                end else if (w_wd_expired) begin
                    o_timeout_err <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_render_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_render_ctrl
//  Description : Self-checking bench for frame_render_ctrl. Each frame is
//                first planned as a timeline of expected events (clear,
//                per-object starts, frame done, timeout) from the input
//                schedules, then driven and compared against what the DUT
//                produced. Offsets are counted in clock edges from the
//                accept edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_render_ctrl;

    localparam int MAXOBJ = 8;
    localparam int OW     = $clog2(MAXOBJ + 1);
    localparam int TO     = 16;
    localparam int TW     = $clog2(TO + 1);
    localparam int LEN    = 1024;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          i_frame_dv = 1'b0;
    logic [OW-1:0] i_num_objects = '0;
    logic          o_frame_ready;
    logic          o_fb_clear;
    logic          i_fb_ready = 1'b0;
    logic          o_render_start;
    logic          i_render_ready = 1'b0;
    logic          i_render_finished = 1'b0;
    logic [OW-1:0] o_object_index;
    logic          o_frame_done;
    logic          o_timeout_err;

    frame_render_ctrl #(
        .MAX_NUM_OBJECTS_PER_FRAME (MAXOBJ),
        .OBJ_CNT_WIDTH             (OW),
        .TIMEOUT_CYCLES            (TO),
        .TIMEOUT_WIDTH             (TW)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .i_frame_dv        (i_frame_dv),
        .i_num_objects     (i_num_objects),
        .o_frame_ready     (o_frame_ready),
        .o_fb_clear        (o_fb_clear),
        .i_fb_ready        (i_fb_ready),
        .o_render_start    (o_render_start),
        .i_render_ready    (i_render_ready),
        .i_render_finished (i_render_finished),
        .o_object_index    (o_object_index),
        .o_frame_done      (o_frame_done),
        .o_timeout_err     (o_timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Input schedules, indexed by the offset of the edge that samples them.
    bit fb_at  [LEN];
    bit rr_at  [LEN];
    bit fin_at [LEN];
    bit dv_at  [LEN];
    bit busy   [LEN];
    int dly    [$];
    int exp_start_o [$];
    int exp_start_i [$];
    int act_start_o [$];
    int act_start_i [$];

    task automatic check(input string tag, input int obs, input int expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, int'(o_frame_ready), 0);
        check({tag, "_clear"}, int'(o_fb_clear), 0);
        check({tag, "_start"}, int'(o_render_start), 0);
        check({tag, "_done"},  int'(o_frame_done), 0);
        check({tag, "_err"},   int'(o_timeout_err), 0);
        check({tag, "_index"}, int'(o_object_index), 0);
    endtask

    task automatic set_dly_const(input int v);
        dly.delete();
        for (int i = 0; i < 10; i++) dly.push_back(v);
    endtask

    task automatic set_dly_rand();
        dly.delete();
        for (int i = 0; i < 10; i++)
            dly.push_back(($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12)));
    endtask

    // dly[k] = edges from start of object k to its finish; 0 = never finishes.
    task automatic run_frame(input int num, input int fb_on, input bit rr_rand,
                             input bit noise, input bit abort_mid);
        int n, p, s, done_o, last_idx, abort_o, acc, n_clear, n_done, done_seen;
        int err;
        n = (num > MAXOBJ) ? MAXOBJ : num;
        for (int i = 0; i < LEN; i++) begin
            fb_at[i]  = (i >= fb_on);
            rr_at[i]  = rr_rand ? ($urandom_range(0, 9) < 7) : 1'b1;
            if (i >= LEN / 2) rr_at[i] = 1'b1;
            fin_at[i] = 1'b0;
            dv_at[i]  = 1'b0;
            busy[i]   = 1'b0;
        end
        exp_start_o.delete(); exp_start_i.delete();
        act_start_o.delete(); act_start_i.delete();

        // Clear at offset 0; i_fb_ready is first honoured at offset 3.
        p = 3;
        while (!fb_at[p]) p++;
        err = 0;
        last_idx = 0;
        if (n == 0) begin
            done_o = p;
        end else begin
            for (int k = 0; k < n; k++) begin
                s = p + 1;
                while (!rr_at[s]) s++;
                exp_start_o.push_back(s);
                exp_start_i.push_back(k);
                last_idx = k;
                if (dly[k] >= 1 && dly[k] <= TO) begin
                    p = s + dly[k];
                    fin_at[p] = 1'b1;
                end else begin
                    p = s + TO;
                    err = 1;
                end
                for (int j = s + 1; j <= p; j++) busy[j] = 1'b1;
                if (err != 0) break;
            end
            done_o = p;
        end
        if (noise) begin
            for (int j = 1; j <= done_o + 1; j++) begin
                if (!busy[j] && ($urandom_range(0, 3) == 0)) fin_at[j] = 1'b1;
                dv_at[j] = ($urandom_range(0, 2) == 0);
            end
        end
        abort_o = (abort_mid && exp_start_o.size() > 1) ? exp_start_o[1] + 2 : -1;

        i_num_objects = OW'(num);
        for (int w = 0; w < 40 && o_frame_ready !== 1'b1; w++) step();
        check("ready_before_accept", int'(o_frame_ready), 1);
        i_frame_dv        = 1'b1;
        i_render_finished = noise;   // spurious finish while idle
        i_fb_ready        = fb_at[0];
        i_render_ready    = rr_at[0];
        acc       = cyc + 1;
        n_clear   = 0;
        n_done    = 0;
        done_seen = -1;
        for (int o = 0; o <= done_o + 1; o++) begin
            step();
            if (o == 0) begin
                check("accept_ready_low", int'(o_frame_ready), 0);
                check("accept_clear_pulse", int'(o_fb_clear), 1);
                check("accept_err_cleared", int'(o_timeout_err), 0);
            end
            if (o_fb_clear === 1'b1) n_clear++;
            if (o_render_start === 1'b1) begin
                act_start_o.push_back(cyc - acc);
                act_start_i.push_back(int'(o_object_index));
            end
            if (o_frame_done === 1'b1) begin
                n_done++;
                done_seen = cyc - acc;
            end
            if (o == abort_o) begin
                check("pre_abort_index", int'(o_object_index), 1);
                #2 rstn = 1'b0;
                #1;
                check_all_zero("async_reset");
                i_frame_dv = 1'b0;
                i_render_finished = 1'b0;
                step();
                check_all_zero("held_reset");
                #2 rstn = 1'b1;
                #1;
                check("release_ready_low", int'(o_frame_ready), 0);
                step();
                check("release_ready_high", int'(o_frame_ready), 1);
                check("release_no_done", int'(o_frame_done), 0);
                return;
            end
            i_fb_ready        = fb_at[o + 1];
            i_render_ready    = rr_at[o + 1];
            i_render_finished = fin_at[o + 1];
            i_frame_dv        = (o + 1 <= done_o + 1) ? dv_at[o + 1] : 1'b0;
            if (noise) i_num_objects = OW'($urandom_range(0, 15));
        end
        i_frame_dv        = 1'b0;
        i_render_finished = 1'b0;

        check("clear_pulses", n_clear, 1);
        check("done_pulses", n_done, 1);
        check("done_offset", done_seen, done_o);
        check("end_ready", int'(o_frame_ready), 1);
        check("end_err", int'(o_timeout_err), err);
        check("end_index", int'(o_object_index), last_idx);
        check("start_count", act_start_o.size(), exp_start_o.size());
        for (int i = 0; i < exp_start_o.size() && i < act_start_o.size(); i++) begin
            check("start_offset", act_start_o[i], exp_start_o[i]);
            check("start_index", act_start_i[i], exp_start_i[i]);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        check_all_zero("reset");
        #2 rstn = 1'b1;
        #1;
        check("ready_before_first_edge", int'(o_frame_ready), 0);
        step();
        check("ready_after_first_edge", int'(o_frame_ready), 1);

        // Three objects, everything ready, finish 5 edges after each start
        set_dly_const(5);
        run_frame(3, 0, 1'b0, 1'b0, 1'b0);
        // Empty frame, display slow to report ready
        run_frame(0, 6, 1'b0, 1'b0, 1'b0);
        // Display ready stuck high through the clear
        set_dly_const(2);
        run_frame(1, 0, 1'b0, 1'b0, 1'b0);
        // Pipeline never finishes: watchdog aborts after first object
        set_dly_const(0);
        run_frame(2, 0, 1'b0, 1'b0, 1'b0);
        // Finish on the very last watchdog cycle still counts
        set_dly_const(TO);
        run_frame(1, 0, 1'b0, 1'b0, 1'b0);
        // Requests above the maximum saturate; exactly at maximum
        set_dly_const(1);
        run_frame(15, 0, 1'b0, 1'b0, 1'b0);
        run_frame(MAXOBJ, 2, 1'b1, 1'b0, 1'b0);
        // Spurious finishes, descriptor noise and changing object count
        set_dly_const(3);
        run_frame(4, 1, 1'b1, 1'b1, 1'b0);
        // Reset while rendering object 1, then a normal one-object frame
        set_dly_const(5);
        run_frame(3, 0, 1'b0, 1'b0, 1'b1);
        set_dly_const(4);
        run_frame(1, 0, 1'b0, 1'b0, 1'b0);

        // Randomized frames
        for (int f = 0; f < 16; f++) begin
            set_dly_rand();
            run_frame(int'($urandom_range(0, 10)), int'($urandom_range(0, 5)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete, observed time limit expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
